// File: rtl/mem_access.sv
// MEM stage of the 5-stage RV32I pipeline: drives the data-memory bus with
// byte-lane alignment, extends load data, stalls the pipeline while an access
// is outstanding, and owns the MEM/WB pipeline register and CSR write port.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_alu_res,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_pcp4,
  input  logic [4:0]  i_wreg,
  input  logic [2:0]  i_wb_ctrl,
  input  logic [1:0]  i_mem_rw,
  input  logic [1:0]  i_dsize,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_csr,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  output logic        o_mem_stall,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_wreg,
  output logic        o_wb_we,
  output logic [31:0] o_fwd_mem_data,
  output logic        o_csr_we,
  output logic [11:0] o_csr_waddr,
  output logic [31:0] o_csr_wdata
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]  w_off;
  logic        w_memOp;
  logic        w_isHalf;
  logic        w_isWord;
  logic        w_misAl;
  logic [31:0] w_lane;
  logic [31:0] w_loadExt;
  logic [31:0] w_result;
  logic        w_req;
  logic        w_stall;
  logic        w_misPulse;
  logic        w_busErr;
  logic        w_done;
  logic        w_retireOk;
  logic        w_wbWe;
  logic        w_csrWe;

  assign w_off    = i_alu_res[1:0];
  assign w_memOp  = |i_mem_rw;
  assign w_isHalf = (i_dsize == 2'b01);
  assign w_isWord = i_dsize[1];
  assign w_misAl  = (w_isHalf & w_off[0]) | (w_isWord & (w_off != 2'b00));
  assign w_lane   = i_dmem_rdata >> {w_off, 3'b000};

  assign o_dmem_addr = {i_alu_res[31:2], 2'b00};

  // Byte enables and lane-replicated store data by access size
  always_comb begin
    o_dmem_be    = 4'hF;
    o_dmem_wdata = i_store_data;
    if (w_isWord) begin
      o_dmem_be    = 4'hF;
      o_dmem_wdata = i_store_data;
    end else if (w_isHalf) begin
      o_dmem_be    = 4'b0011 << w_off;
      o_dmem_wdata = {2{i_store_data[15:0]}};
    end else begin
      o_dmem_be    = 4'b0001 << w_off;
      o_dmem_wdata = {4{i_store_data[7:0]}};
    end
  end

  // Load lane extension; any undefined load type behaves as a full word
  always_comb begin
    w_loadExt = w_lane;
    case (i_funct3)
      3'b000:  w_loadExt = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_loadExt = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_loadExt = {24'd0, w_lane[7:0]};
      3'b101:  w_loadExt = {16'd0, w_lane[15:0]};
      default: w_loadExt = w_lane;
    endcase
  end

  // Access FSM: next state plus request, stall and fault pulses
  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_stall    = 1'b0;
    w_misPulse = 1'b0;
    w_busErr   = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memOp) begin
          if (w_misAl) begin
            w_misPulse = 1'b1;
          end else begin
            w_req = 1'b1;
            if (i_dmem_ack) begin
              w_done = 1'b1;
            end else begin
              w_stall = 1'b1;
              w_next  = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (i_dmem_ack) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (r_cnt == TIMEOUT_CNT) begin
          w_busErr = 1'b1;
          w_next   = S_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_dmem_req  = rst & w_req;
  assign o_dmem_we   = rst & w_req & i_mem_rw[0];
  assign o_mem_stall = rst & w_stall;
  assign o_misalign  = rst & w_misPulse;
  assign o_bus_err   = rst & w_busErr;

  // A load that never completed (misaligned or timed out) contributes zero
  assign w_result = (i_wb_ctrl[2:1] == 2'b01) ? (w_done ? w_loadExt : 32'd0) :
                    (i_wb_ctrl[2:1] == 2'b10) ? i_pcp4 : i_alu_res;

  assign o_fwd_mem_data = w_result;
  assign w_retireOk     = ~w_misPulse & ~w_busErr;
  assign w_wbWe         = i_wb_ctrl[0] & (i_wreg != 5'd0) & ~i_mem_rw[0] & w_retireOk;
  assign w_csrWe        = i_is_csr & w_retireOk;

  // State register; reset abandons any outstanding access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Wait counter: starts at 1 on entering WAIT, clears on leaving
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        r_cnt <= '0;
    else if (r_state == S_IDLE && w_next == S_WAIT)  r_cnt <= CNT_W'(1);
    else if (r_state == S_WAIT && w_next == S_WAIT)  r_cnt <= r_cnt + CNT_W'(1);
    else                                             r_cnt <= '0;
  end

  // MEM/WB and CSR write register; a bubble is captured while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_wb_data   <= '0;
      o_wb_wreg   <= '0;
      o_wb_we     <= 1'b0;
      o_csr_we    <= 1'b0;
      o_csr_waddr <= '0;
      o_csr_wdata <= '0;
    end else if (w_stall) begin
      o_wb_we  <= 1'b0;
      o_csr_we <= 1'b0;
    end else begin
      o_wb_data   <= w_result;
      o_wb_wreg   <= i_wreg;
      o_wb_we     <= w_wbWe;
      o_csr_we    <= w_csrWe;
      o_csr_waddr <= i_csr_addr;
      o_csr_wdata <= i_csr_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for the MEM pipeline stage.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic [31:0] aluRes;
  logic [31:0] storeData;
  logic [31:0] pcp4;
  logic [4:0]  wreg;
  logic [2:0]  wbCtrl;
  logic [1:0]  memRw;
  logic [1:0]  dsize;
  logic [2:0]  funct3;
  logic        isCsr;
  logic [11:0] csrAddr;
  logic [31:0] csrWdata;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata;
  logic [31:0] dmemRdata;
  logic        dmemAck;
  logic        memStall;
  logic        misalign;
  logic        busErr;
  logic [31:0] wbData;
  logic [4:0]  wbWreg;
  logic        wbWe;
  logic [31:0] fwdMemData;
  logic        csrWe;
  logic [11:0] csrWaddr;
  logic [31:0] csrWdataO;

  int testsRun = 0;
  int failCount = 0;
  int stallCnt;
  int reqCnt;
  logic seen;

  mem_access #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .i_alu_res(aluRes), .i_store_data(storeData), .i_pcp4(pcp4),
    .i_wreg(wreg), .i_wb_ctrl(wbCtrl), .i_mem_rw(memRw), .i_dsize(dsize),
    .i_funct3(funct3), .i_is_csr(isCsr), .i_csr_addr(csrAddr),
    .i_csr_wdata(csrWdata),
    .o_dmem_req(dmemReq), .o_dmem_we(dmemWe), .o_dmem_addr(dmemAddr),
    .o_dmem_be(dmemBe), .o_dmem_wdata(dmemWdata),
    .i_dmem_rdata(dmemRdata), .i_dmem_ack(dmemAck),
    .o_mem_stall(memStall), .o_misalign(misalign), .o_bus_err(busErr),
    .o_wb_data(wbData), .o_wb_wreg(wbWreg), .o_wb_we(wbWe),
    .o_fwd_mem_data(fwdMemData),
    .o_csr_we(csrWe), .o_csr_waddr(csrWaddr), .o_csr_wdata(csrWdataO)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] rw,
                               input logic [1:0] sz, input logic [2:0] f3,
                               input logic [2:0] ctrl, input logic [4:0] rd);
    aluRes = a;
    memRw  = rw;
    dsize  = sz;
    funct3 = f3;
    wbCtrl = ctrl;
    wreg   = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    storeData = '0;
    pcp4      = '0;
    isCsr     = 1'b0;
    csrAddr   = '0;
    csrWdata  = '0;
    dmemRdata = '0;
    dmemAck   = 1'b0;
    applyStimulus(32'h0000_1000, 2'b10, 2'b10, 3'b010, 3'b011, 5'd1);

    // Reset: outputs held low even with a load presented
    #12;
    checkOutput("rst_req", dmemReq, 1'b0);
    checkOutput("rst_stall", memStall, 1'b0);
    checkOutput("rst_wb_we", wbWe, 1'b0);
    checkOutput("rst_wb_data", wbData, 32'h0);
    checkOutput("rst_csr_we", csrWe, 1'b0);
    applyStimulus(32'h0, 2'b00, 2'b00, 3'b000, 3'b000, 5'd0);
    rst = 1'b1;
    nextCycle();

    // LB from 0x1003, zero wait states
    applyStimulus(32'h0000_1003, 2'b10, 2'b00, 3'b000, 3'b011, 5'd5);
    dmemRdata = 32'h80FF_FF12;
    dmemAck   = 1'b1;
    #1;
    checkOutput("lb_req", dmemReq, 1'b1);
    checkOutput("lb_we", dmemWe, 1'b0);
    checkOutput("lb_be", dmemBe, 4'b1000);
    checkOutput("lb_addr", dmemAddr, 32'h0000_1000);
    checkOutput("lb_stall", memStall, 1'b0);
    checkOutput("lb_fwd", fwdMemData, 32'hFFFF_FF80);
    nextCycle();
    checkOutput("lb_wb_data", wbData, 32'hFFFF_FF80);
    checkOutput("lb_wb_we", wbWe, 1'b1);
    checkOutput("lb_wb_wreg", wbWreg, 5'd5);

    // Back-to-back loads, other extension modes, same read word
    applyStimulus(32'h0000_1003, 2'b10, 2'b00, 3'b100, 3'b011, 5'd6);
    #1;
    checkOutput("lbu_fwd", fwdMemData, 32'h0000_0080);
    nextCycle();
    applyStimulus(32'h0000_1002, 2'b10, 2'b01, 3'b001, 3'b011, 5'd6);
    #1;
    checkOutput("lh_be", dmemBe, 4'b1100);
    checkOutput("lh_fwd", fwdMemData, 32'hFFFF_80FF);
    nextCycle();
    applyStimulus(32'h0000_1002, 2'b10, 2'b01, 3'b101, 3'b011, 5'd6);
    #1;
    checkOutput("lhu_fwd", fwdMemData, 32'h0000_80FF);
    nextCycle();
    applyStimulus(32'h0000_1000, 2'b10, 2'b10, 3'b010, 3'b011, 5'd6);
    #1;
    checkOutput("lw_fwd", fwdMemData, 32'h80FF_FF12);
    nextCycle();
    checkOutput("lw_wb_data", wbData, 32'h80FF_FF12);

    // SH at 0x2002, ack on the fourth request cycle
    applyStimulus(32'h0000_2002, 2'b01, 2'b01, 3'b001, 3'b001, 5'd7);
    storeData = 32'h0000_BEEF;
    reqCnt    = 0;
    stallCnt  = 0;
    for (int k = 0; k < 4; k++) begin
      dmemAck = (k == 3);
      #1;
      if (dmemReq) reqCnt++;
      if (memStall) stallCnt++;
      checkOutput("sh_be", dmemBe, 4'b1100);
      checkOutput("sh_wdata", dmemWdata, 32'hBEEF_BEEF);
      checkOutput("sh_we", dmemWe, 1'b1);
      nextCycle();
      checkOutput("sh_wb_we", wbWe, 1'b0);
    end
    checkOutput("sh_req_cycles", reqCnt, 4);
    checkOutput("sh_stall_cycles", stallCnt, 3);

    // Misaligned LW at 0x3001
    applyStimulus(32'h0000_3001, 2'b10, 2'b10, 3'b010, 3'b001, 5'd3);
    dmemAck = 1'b0;
    #1;
    checkOutput("mis_pulse", misalign, 1'b1);
    checkOutput("mis_req", dmemReq, 1'b0);
    checkOutput("mis_stall", memStall, 1'b0);
    nextCycle();
    checkOutput("mis_wb_we", wbWe, 1'b0);
    checkOutput("mis_wb_data", wbData, 32'h0000_3001);
    applyStimulus(32'h0, 2'b00, 2'b00, 3'b000, 3'b000, 5'd0);
    #1;
    checkOutput("mis_pulse_end", misalign, 1'b0);
    nextCycle();

    // LW with no ack: timeout after 16 stalled cycles
    applyStimulus(32'h0000_4000, 2'b10, 2'b10, 3'b010, 3'b011, 5'd4);
    stallCnt = 0;
    seen     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (busErr) begin
        seen = 1'b1;
        break;
      end
      if (memStall) stallCnt++;
      @(posedge clk);
    end
    checkOutput("to_seen", seen, 1'b1);
    checkOutput("to_stall_cycles", stallCnt, 16);
    checkOutput("to_stall_drop", memStall, 1'b0);
    nextCycle();
    checkOutput("to_wb_we", wbWe, 1'b0);
    checkOutput("to_wb_data", wbData, 32'h0);
    checkOutput("to_bus_err_end", busErr, 1'b0);

    // Back in IDLE: zero-wait LW completes
    applyStimulus(32'h0000_4004, 2'b10, 2'b10, 3'b010, 3'b011, 5'd4);
    dmemRdata = 32'h1234_5678;
    dmemAck   = 1'b1;
    #1;
    checkOutput("post_to_stall", memStall, 1'b0);
    nextCycle();
    checkOutput("post_to_wb_data", wbData, 32'h1234_5678);
    checkOutput("post_to_wb_we", wbWe, 1'b1);

    // Reset asserted during the second WAIT cycle
    applyStimulus(32'h0000_5000, 2'b10, 2'b10, 3'b010, 3'b011, 5'd8);
    dmemAck = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rw_stall_before", memStall, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("rw_req", dmemReq, 1'b0);
    checkOutput("rw_stall", memStall, 1'b0);
    checkOutput("rw_wb_data", wbData, 32'h0);
    checkOutput("rw_wb_we", wbWe, 1'b0);
    applyStimulus(32'h0, 2'b00, 2'b00, 3'b000, 3'b000, 5'd0);
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("rw_idle_req", dmemReq, 1'b0);
    checkOutput("rw_idle_stall", memStall, 1'b0);
    checkOutput("rw_csr_we", csrWe, 1'b0);
    nextCycle();

    // JAL-style PC+4 writeback, then CSR write
    applyStimulus(32'h0000_DEAD, 2'b00, 2'b00, 3'b000, 3'b101, 5'd1);
    pcp4 = 32'h0000_0104;
    #1;
    checkOutput("jal_fwd", fwdMemData, 32'h0000_0104);
    nextCycle();
    checkOutput("jal_wb_data", wbData, 32'h0000_0104);
    checkOutput("jal_wb_we", wbWe, 1'b1);
    checkOutput("jal_wb_wreg", wbWreg, 5'd1);
    checkOutput("jal_csr_we", csrWe, 1'b0);
    applyStimulus(32'h0000_0000, 2'b00, 2'b00, 3'b000, 3'b001, 5'd0);
    isCsr    = 1'b1;
    csrAddr  = 12'h305;
    csrWdata = 32'h0000_0080;
    nextCycle();
    checkOutput("csr_we", csrWe, 1'b1);
    checkOutput("csr_waddr", csrWaddr, 12'h305);
    checkOutput("csr_wdata", csrWdataO, 32'h0000_0080);
    checkOutput("x0_wb_we", wbWe, 1'b0);
    isCsr = 1'b0;
    nextCycle();
    checkOutput("csr_we_end", csrWe, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
